ap_errmon_sweep: RTL and testbench

//  Self-contained error-characterisation harness stage for the approximate unsigned multipliers.

---
 rtl/ap_errmon_sweep_if.sv | 56 +++++
 rtl/ap_errmon_sweep.sv | 170 +++++++++++++++++
 tb/tb_ap_errmon_sweep.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ap_errmon_sweep_if.sv
// Bus between the error-monitor sweep harness and the approximate multiplier
// under evaluation, plus the start handshake and the reported metrics.
// Optional worst-case operand outputs are present when AP_ERRMON_WCE_EN is defined.
interface ap_errmon_sweep_if #(
    parameter int DW = 4
);
    logic              start;
    logic [DW-1:0]     muld;
    logic [DW-1:0]     mulr;
    logic [2*DW-1:0]   res;
    logic              busy;
    logic              done;
    logic [2*DW:0]     err_cnt;
    logic [4*DW-1:0]   sum_ed;
    logic [2*DW-1:0]   max_ed;
`ifdef AP_ERRMON_WCE_EN
    logic [DW-1:0]     wce_muld;
    logic [DW-1:0]     wce_mulr;
`endif

    // Harness side: drives operands, consumes the product, reports metrics.
    modport master (
        input  start,
        input  res,
        output muld,
        output mulr,
        output busy,
        output done,
        output err_cnt,
        output sum_ed,
        output max_ed
`ifdef AP_ERRMON_WCE_EN
        ,
        output wce_muld,
        output wce_mulr
`endif
    );

    // Environment side: multiplier under test plus whoever reads the metrics.
    modport slave (
        output start,
        output res,
        input  muld,
        input  mulr,
        input  busy,
        input  done,
        input  err_cnt,
        input  sum_ed,
        input  max_ed
`ifdef AP_ERRMON_WCE_EN
        ,
        input  wce_muld,
        input  wce_mulr
`endif
    );
endinterface

// File: rtl/ap_errmon_sweep.sv
// Exhaustive error-characterisation sweep for an approximate unsigned multiplier.
// Drives every muld/mulr pair once, lines each returned product up with its
// operands through a LAT-deep pipeline, and accumulates error count, sum of
// error distance and maximum error distance.
// Optional feature macro: AP_ERRMON_WCE_EN (adds the operand pair of the first
// worst-case error as wce_muld/wce_mulr).
module ap_errmon_sweep #(
    parameter int DW  = 4,
    parameter int LAT = 0
) (
    input logic clk,
    input logic rst,
    ap_errmon_sweep_if.master bus
);
    localparam int IW = 2 * DW;
    localparam int EW = 2 * DW + 1;
    localparam int SW = 4 * DW;
    localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] DRAIN_LAST = (LAT > 0) ? CW'(LAT - 1) : '0;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   drain_cnt;
    logic            accept;

    logic            score_valid;
    logic [DW-1:0]   score_d;
    logic [DW-1:0]   score_r;
    logic [IW-1:0]   exact;
    logic [IW-1:0]   ed;

    logic [EW-1:0]   err_cnt;
    logic [SW-1:0]   sum_ed;
    logic [IW-1:0]   max_ed;

    assign accept   = (state == IDLE) && bus.start;
    assign bus.muld = idx[DW-1:0];
    assign bus.mulr = idx[IW-1:DW];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and the busy/done status decoded from the state.
    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = SWEEP;
            end
            SWEEP: begin
                bus.busy = 1'b1;
                if (idx == '1) state_next = (LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep index and drain counter; idx doubles as the registered operand pair
    // and simply stays at its last value once the sweep is over.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept)
                idx <= '0;
            else if (state == SWEEP && idx != '1)
                idx <= idx + IW'(1);
            if (state == DRAIN)
                drain_cnt <= drain_cnt + CW'(1);
            else
                drain_cnt <= '0;
        end
    end

    // Align the operand pair with the product it produced.
    generate
        if (LAT == 0) begin : g_comb
            assign score_valid = (state == SWEEP);
            assign score_d     = idx[DW-1:0];
            assign score_r     = idx[IW-1:DW];
        end else begin : g_pipe
            logic [LAT-1:0] pipe_v;
            logic [DW-1:0]  pipe_d [LAT];
            logic [DW-1:0]  pipe_r [LAT];

            // Shift the pair and its valid bit along with the multiplier latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_v <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        pipe_d[i] <= '0;
                        pipe_r[i] <= '0;
                    end
                end else begin
                    pipe_v[0] <= (state == SWEEP);
                    pipe_d[0] <= idx[DW-1:0];
                    pipe_r[0] <= idx[IW-1:DW];
                    for (int i = 1; i < LAT; i++) begin
                        pipe_v[i] <= pipe_v[i-1];
                        pipe_d[i] <= pipe_d[i-1];
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign score_valid = pipe_v[LAT-1];
            assign score_d     = pipe_d[LAT-1];
            assign score_r     = pipe_r[LAT-1];
        end
    endgenerate

    // Exact product and absolute error distance of the sample being scored.
    always_comb begin
        exact = IW'(score_d) * IW'(score_r);
        ed    = (exact >= bus.res) ? (exact - bus.res) : (bus.res - exact);
    end

    // Metric accumulation; an accepted start clears everything for the new run.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_cnt <= '0;
            sum_ed  <= '0;
            max_ed  <= '0;
        end else if (score_valid) begin
            if (ed != '0) err_cnt <= err_cnt + EW'(1);
            sum_ed <= sum_ed + SW'(ed);
            if (ed > max_ed) max_ed <= ed;
        end
    end

    assign bus.err_cnt = err_cnt;
    assign bus.sum_ed  = sum_ed;
    assign bus.max_ed  = max_ed;

`ifdef AP_ERRMON_WCE_EN
    logic [DW-1:0] wce_muld;
    logic [DW-1:0] wce_mulr;

    // Operands of the first worst-case error; ties keep the earlier pair.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            wce_muld <= '0;
            wce_mulr <= '0;
        end else if (score_valid && ed > max_ed) begin
            wce_muld <= score_d;
            wce_mulr <= score_r;
        end
    end

    assign bus.wce_muld = wce_muld;
    assign bus.wce_mulr = wce_mulr;
`endif
endmodule

// File: tb/tb_ap_errmon_sweep.sv
// Self-checking bench for ap_errmon_sweep: three harness instances (LAT=0 with
// a selectable approximate multiplier, LAT=2 and LAT=0 against a two-stage
// registered exact multiplier). Expected metrics come from a bench-side
// sweep model pushed to a scoreboard queue at start and popped at done.
module tb_ap_errmon_sweep;
    localparam int DW = 4;
    localparam int NP = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mode_a = 0;

    always #5 clk = ~clk;

    ap_errmon_sweep_if #(.DW(DW)) bus_a ();
    ap_errmon_sweep_if #(.DW(DW)) bus_b ();
    ap_errmon_sweep_if #(.DW(DW)) bus_c ();

    ap_errmon_sweep #(.DW(DW), .LAT(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ap_errmon_sweep #(.DW(DW), .LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    ap_errmon_sweep #(.DW(DW), .LAT(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    // Approximate multiplier models: 0 exact, 1 tied to zero, 2 bit0 forced low.
    function automatic logic [7:0] approx_res(input int mode, input logic [3:0] d, input logic [3:0] r);
        logic [7:0] p;
        p = {4'b0, d} * {4'b0, r};
        case (mode)
            1:       return 8'd0;
            2:       return p & 8'hFE;
            default: return p;
        endcase
    endfunction

    always_comb bus_a.res = approx_res(mode_a, bus_a.muld, bus_a.mulr);

    // Exact multiplier registered twice, shared shape for instances b and c.
    logic [7:0] b_p1, b_p2, c_p1, c_p2;
    always_ff @(posedge clk) begin
        b_p1 <= {4'b0, bus_b.muld} * {4'b0, bus_b.mulr};
        b_p2 <= b_p1;
        c_p1 <= {4'b0, bus_c.muld} * {4'b0, bus_c.mulr};
        c_p2 <= c_p1;
    end
    assign bus_b.res = b_p2;
    assign bus_c.res = c_p2;

    typedef struct {
        int     err;
        longint sum;
        int     mx;
        int     wd;
        int     wr;
        int     done_cyc;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t model(input int mode, input int lat);
        exp_t e;
        int d, r, ex, a, ed;
        e.err = 0; e.sum = 0; e.mx = 0; e.wd = 0; e.wr = 0;
        e.done_cyc = NP + lat + 1;
        for (int i = 0; i < NP; i++) begin
            d  = i % 16;
            r  = i / 16;
            ex = d * r;
            a  = int'(approx_res(mode, 4'(d), 4'(r)));
            ed = (ex >= a) ? ex - a : a - ex;
            if (ed != 0) e.err++;
            e.sum += ed;
            if (ed > e.mx) begin
                e.mx = ed;
                e.wd = d;
                e.wr = r;
            end
        end
        return e;
    endfunction

    // Pulse start on instance a; returns at the negedge of cycle 1.
    task automatic start_a();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    // Wait for done on instance a, counting cycles from cycle 1.
    task automatic wait_done_a(input int limit, output int n, output bit seen);
        n = 1;
        seen = 1'b0;
        while (n <= limit) begin
            if (bus_a.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus_a.muld !== 4'd0 || bus_a.mulr !== 4'd0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got muld=%0d mulr=%0d busy=%b done=%b, expected all 0",
                     bus_a.muld, bus_a.mulr, bus_a.busy, bus_a.done);
        end
        checks++;
        if (bus_a.err_cnt !== 9'd0 || bus_a.sum_ed !== 16'd0 || bus_a.max_ed !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_metrics: got err=%0d sum=%0d max=%0d, expected 0",
                     bus_a.err_cnt, bus_a.sum_ed, bus_a.max_ed);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_b.busy !== 1'b0 || bus_b.done !== 1'b0 || bus_b.err_cnt !== 9'd0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got b.busy=%b b.done=%b b.err=%0d a.busy=%b, expected 0",
                     bus_b.busy, bus_b.done, bus_b.err_cnt, bus_a.busy);
        end
    endtask

    task automatic test_sweep(input int mode, input string name);
        exp_t e;
        int   n;
        bit   seen;
        mode_a = mode;
        sb_q.push_back(model(mode, 0));
        start_a();
        checks++;
        if (bus_a.busy !== 1'b1 || {bus_a.mulr, bus_a.muld} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL %s first_pair: got busy=%b idx=%0d, expected busy=1 idx=0",
                     name, bus_a.busy, {bus_a.mulr, bus_a.muld});
        end
        wait_done_a(400, n, seen);
        e = sb_q.pop_front();
        checks++;
        if (!seen || n != e.done_cyc) begin
            errors++;
            $display("[TB] FAIL %s done_cycle: got %0d (seen=%0b), expected %0d", name, n, seen, e.done_cyc);
        end
        checks++;
        if (bus_a.err_cnt !== 9'(e.err)) begin
            errors++;
            $display("[TB] FAIL %s err_cnt: got %0d, expected %0d", name, bus_a.err_cnt, e.err);
        end
        checks++;
        if (bus_a.sum_ed !== 16'(e.sum)) begin
            errors++;
            $display("[TB] FAIL %s sum_ed: got %0d, expected %0d", name, bus_a.sum_ed, e.sum);
        end
        checks++;
        if (bus_a.max_ed !== 8'(e.mx)) begin
            errors++;
            $display("[TB] FAIL %s max_ed: got %0d, expected %0d", name, bus_a.max_ed, e.mx);
        end
`ifdef AP_ERRMON_WCE_EN
        checks++;
        if (bus_a.wce_muld !== 4'(e.wd) || bus_a.wce_mulr !== 4'(e.wr)) begin
            errors++;
            $display("[TB] FAIL %s wce_pair: got (%0d,%0d), expected (%0d,%0d)",
                     name, bus_a.wce_muld, bus_a.wce_mulr, e.wd, e.wr);
        end
`endif
        @(negedge clk);
        checks++;
        if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s after_done: got done=%b busy=%b, expected 0 0", name, bus_a.done, bus_a.busy);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        int   n, nb, nc;
        bit   seen_b, seen_c;
        logic [8:0] err_c;
        seen_b = 1'b0; seen_c = 1'b0; nb = 0; nc = 0; err_c = '0;
        sb_q.push_back(model(0, 2));
        bus_b.start = 1'b1;
        bus_c.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        n = 1;
        while (n <= 400 && !(seen_b && seen_c)) begin
            if (!seen_c && bus_c.done === 1'b1) begin
                seen_c = 1'b1;
                nc = n;
                err_c = bus_c.err_cnt;
            end
            if (!seen_b && bus_b.done === 1'b1) begin
                seen_b = 1'b1;
                nb = n;
                e = sb_q.pop_front();
                checks++;
                if (nb != e.done_cyc) begin
                    errors++;
                    $display("[TB] FAIL lat2_done_cycle: got %0d, expected %0d", nb, e.done_cyc);
                end
                checks++;
                if (bus_b.err_cnt !== 9'(e.err) || bus_b.sum_ed !== 16'(e.sum) || bus_b.max_ed !== 8'(e.mx)) begin
                    errors++;
                    $display("[TB] FAIL lat2_metrics: got err=%0d sum=%0d max=%0d, expected %0d %0d %0d",
                             bus_b.err_cnt, bus_b.sum_ed, bus_b.max_ed, e.err, e.sum, e.mx);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (!seen_b) begin
            errors++;
            $display("[TB] FAIL lat2_timeout: got no done, expected done by cycle %0d", NP + 3);
        end
        checks++;
        if (!seen_c || nc != NP + 1 || err_c === 9'd0) begin
            errors++;
            $display("[TB] FAIL misaligned: got seen=%0b cycle=%0d err=%0d, expected cycle %0d err nonzero",
                     seen_c, nc, err_c, NP + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit found, any_done;
        mode_a = 2;
        start_a();
        n = 1;
        found = 1'b0;
        while (n <= 300) begin
            if ({bus_a.mulr, bus_a.muld} === 8'd100 && bus_a.busy === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (!found || bus_a.err_cnt === 9'd0) begin
            errors++;
            $display("[TB] FAIL mid_reach_idx100: got found=%0b err=%0d, expected found with nonzero err",
                     found, bus_a.err_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.muld !== 4'd0 || bus_a.mulr !== 4'd0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_ctrl: got muld=%0d mulr=%0d busy=%b done=%b, expected all 0",
                     bus_a.muld, bus_a.mulr, bus_a.busy, bus_a.done);
        end
        checks++;
        if (bus_a.err_cnt !== 9'd0 || bus_a.sum_ed !== 16'd0 || bus_a.max_ed !== 8'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_metrics: got err=%0d sum=%0d max=%0d, expected 0",
                     bus_a.err_cnt, bus_a.sum_ed, bus_a.max_ed);
        end
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) any_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (any_done) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_done: got done/busy activity, expected none");
        end
    endtask

    task automatic test_ignored_start();
        exp_t e;
        int   n, dones, done_n;
        bit   p50, seen;
        logic [8:0]  err_d;
        logic [15:0] sum_d;
        logic [7:0]  max_d;
        mode_a = 2;
        sb_q.push_back(model(2, 0));
        start_a();
        dones = 0; done_n = 0; p50 = 1'b0;
        err_d = '0; sum_d = '0; max_d = '0;
        for (n = 1; n <= 320; n++) begin
            bus_a.start = 1'b0;
            if (bus_a.done === 1'b1) begin
                dones++;
                done_n = n;
                err_d = bus_a.err_cnt;
                sum_d = bus_a.sum_ed;
                max_d = bus_a.max_ed;
                bus_a.start = 1'b1;
            end else if (!p50 && bus_a.busy === 1'b1 && {bus_a.mulr, bus_a.muld} === 8'd50) begin
                p50 = 1'b1;
                bus_a.start = 1'b1;
            end
            @(negedge clk);
        end
        bus_a.start = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (dones != 1 || done_n != e.done_cyc || !p50) begin
            errors++;
            $display("[TB] FAIL ign_single_done: got dones=%0d at %0d p50=%0b, expected 1 at %0d",
                     dones, done_n, p50, e.done_cyc);
        end
        checks++;
        if (err_d !== 9'(e.err) || sum_d !== 16'(e.sum) || max_d !== 8'(e.mx)) begin
            errors++;
            $display("[TB] FAIL ign_metrics: got err=%0d sum=%0d max=%0d, expected %0d %0d %0d",
                     err_d, sum_d, max_d, e.err, e.sum, e.mx);
        end
        checks++;
        if (bus_a.err_cnt !== 9'(e.err) || bus_a.sum_ed !== 16'(e.sum) || bus_a.max_ed !== 8'(e.mx) ||
            bus_a.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ign_hold: got err=%0d sum=%0d max=%0d busy=%b, expected %0d %0d %0d 0",
                     bus_a.err_cnt, bus_a.sum_ed, bus_a.max_ed, bus_a.busy, e.err, e.sum, e.mx);
        end
        mode_a = 0;
        start_a();
        checks++;
        if (bus_a.err_cnt !== 9'd0 || bus_a.sum_ed !== 16'd0 || bus_a.max_ed !== 8'd0) begin
            errors++;
            $display("[TB] FAIL restart_clear: got err=%0d sum=%0d max=%0d, expected 0",
                     bus_a.err_cnt, bus_a.sum_ed, bus_a.max_ed);
        end
`ifdef AP_ERRMON_WCE_EN
        checks++;
        if (bus_a.wce_muld !== 4'd0 || bus_a.wce_mulr !== 4'd0) begin
            errors++;
            $display("[TB] FAIL restart_wce_clear: got (%0d,%0d), expected (0,0)", bus_a.wce_muld, bus_a.wce_mulr);
        end
`endif
        wait_done_a(400, n, seen);
        checks++;
        if (!seen || n != NP + 1) begin
            errors++;
            $display("[TB] FAIL restart_done: got cycle %0d (seen=%0b), expected %0d", n, seen, NP + 1);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_sweep(0, "exact");
        test_sweep(1, "zero_res");
        test_sweep(2, "bit0_clear");
        test_latency();
        test_reset_mid();
        test_sweep(0, "after_reset");
        test_ignored_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
